// File: rtl/pe_psum_ss.sv
// pe_psum_ss: shift-and-sum stage between the Aunit and the psum pad.
// Two-stage pipeline: S0 accepts the op and issues the pad read, S1 combines
// the Aunit result with the (optionally shifted) base and writes it back.
// Finished psums (lstpix) are drained through a 2-entry output FIFO.
// Optional feature macro: PSUM_SAT_EN (saturating shift/sum instead of wrap).
//
// ss_ctl layout (msb..lsb): {valid, init, fstpix, lstpix, sht, sht_num[1:0]}
//   sht_num: 0=SHT1, 1=SHT2, 2=SHT4, 3=SHT8
// pp_addr layout (msb..lsb): {raddr, waddr, read, write}
module pe_psum_ss #(
  parameter int PsumDWd    = 16,
  parameter int AuODWd     = 16,
  parameter int PPadSize   = 64,
  parameter int PPadAddrWd = $clog2(PPadSize)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                ss_ctl,
  input  logic [PPadAddrWd-1:0]     psum_last,
  input  logic [AuODWd-1:0]         au_data,
  output logic [2*PPadAddrWd+1:0]   pp_addr,
  input  logic [PsumDWd-1:0]        pp_rdata,
  output logic [PsumDWd-1:0]        pp_wdata,
  output logic                      stall,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PsumDWd-1:0]        out_data
);

  localparam logic [PsumDWd-1:0] PMax = {1'b0, {(PsumDWd-1){1'b1}}};
  localparam logic [PsumDWd-1:0] PMin = {1'b1, {(PsumDWd-1){1'b0}}};
`ifdef PSUM_SAT_EN
  // carry bit is needed to detect overflow before clamping
  localparam int SumW = PsumDWd + 1;
`else
  localparam int SumW = PsumDWd;
`endif

  logic                  c_valid, c_init, c_fst, c_lst, c_sht;
  logic [1:0]            c_shtn;
  assign {c_valid, c_init, c_fst, c_lst, c_sht, c_shtn} = ss_ctl;

  logic [PPadAddrWd-1:0] ptr_q, ptr_d, s1_addr_q, s1_addr_d;
  logic                  s1_vld_q, s1_vld_d, s1_fst_q, s1_fst_d, s1_lst_q, s1_lst_d;
  logic                  s1_sht_q, s1_sht_d, fwd_q, fwd_d;
  logic [1:0]            s1_shtn_q, s1_shtn_d, cnt_q, cnt_d, cnt_p;
  logic [AuODWd-1:0]     s1_au_q, s1_au_d;
  logic [PsumDWd-1:0]    fwd_data_q, fwd_data_d, f0_q, f0_d, f1_q, f1_d;

  logic [PsumDWd-1:0]    base, shifted, result;
  logic [3:0]            sh_amt;
  logic signed [SumW-1:0] au_ext, sh_ext, sum;
`ifdef PSUM_SAT_EN
  logic [PsumDWd+7:0]    base_w, shl_w;
`endif
  logic [2:0]            occ;
  logic                  accept, do_op, rd, s1_wr, push, pop;
  logic [PPadAddrWd-1:0] rd_addr, wr_addr;

  // S1 datapath: pick base (zero / forwarded / pad), shift, add, reduce
  always_comb begin
    base = '0;
    if (!s1_fst_q) base = fwd_q ? fwd_data_q : pp_rdata;
    case (s1_shtn_q)
      2'd0:    sh_amt = 4'd1;
      2'd1:    sh_amt = 4'd2;
      2'd2:    sh_amt = 4'd4;
      default: sh_amt = 4'd8;
    endcase
`ifdef PSUM_SAT_EN
    base_w  = {{8{base[PsumDWd-1]}}, base};
    shl_w   = base_w << sh_amt;
    shifted = shl_w[PsumDWd-1:0];
    // any bit shifted past the sign position means the value no longer fits
    if (shl_w[PsumDWd+7:PsumDWd-1] != {9{base[PsumDWd-1]}})
      shifted = base[PsumDWd-1] ? PMin : PMax;
`else
    shifted = base << sh_amt;
`endif
    if (!s1_sht_q) shifted = base;
    au_ext = SumW'($signed(s1_au_q));
    sh_ext = SumW'($signed(shifted));
    sum    = au_ext + sh_ext;
    result = sum[PsumDWd-1:0];
`ifdef PSUM_SAT_EN
    if (sum[PsumDWd] != sum[PsumDWd-1]) result = sum[PsumDWd] ? PMin : PMax;
`endif
  end

  // handshake, pad port and next-state for pointer, S1 and the output FIFO
  always_comb begin
    occ       = {1'b0, cnt_q} + {2'b0, s1_vld_q & s1_lst_q};
    stall     = occ >= 3'd2;
    accept    = c_valid & ~stall & ~rst;
    do_op     = accept & ~c_init;
    rd        = do_op & ~c_fst;
    s1_wr     = s1_vld_q & ~rst;
    push      = s1_wr & s1_lst_q;
    out_valid = cnt_q != 2'd0;
    pop       = out_valid & out_ready;
    rd_addr   = rd ? ptr_q : '0;
    wr_addr   = s1_wr ? s1_addr_q : '0;
    pp_addr   = {rd_addr, wr_addr, rd, s1_wr};
    pp_wdata  = s1_wr ? result : '0;
    out_data  = f0_q;

    ptr_d = ptr_q;
    if (accept) begin
      if (c_init || ptr_q == psum_last) ptr_d = '0;
      else                              ptr_d = ptr_q + PPadAddrWd'(1);
    end

    s1_vld_d  = do_op;
    s1_addr_d = s1_addr_q;
    s1_fst_d  = s1_fst_q;
    s1_lst_d  = s1_lst_q;
    s1_sht_d  = s1_sht_q;
    s1_shtn_d = s1_shtn_q;
    s1_au_d   = s1_au_q;
    if (do_op) begin
      s1_addr_d = ptr_q;
      s1_fst_d  = c_fst;
      s1_lst_d  = c_lst;
      s1_sht_d  = c_sht;
      s1_shtn_d = c_shtn;
      s1_au_d   = au_data;
    end
    // pad read this cycle returns stale data if S1 is writing the same word
    fwd_d      = do_op & s1_wr & (s1_addr_q == ptr_q);
    fwd_data_d = result;

    cnt_p = cnt_q - {1'b0, pop};
    f0_d  = f0_q;
    f1_d  = f1_q;
    if (pop && cnt_q == 2'd2) f0_d = f1_q;
    if (push) begin
      if (cnt_p == 2'd0) f0_d = result;
      else               f1_d = result;
    end
    cnt_d = cnt_p + {1'b0, push};
  end

  // state registers; reset drops the S1 op and flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_fst_q   <= 1'b0;
      s1_lst_q   <= 1'b0;
      s1_sht_q   <= 1'b0;
      s1_shtn_q  <= '0;
      s1_au_q    <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      f0_q       <= '0;
      f1_q       <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_vld_q   <= s1_vld_d;
      s1_addr_q  <= s1_addr_d;
      s1_fst_q   <= s1_fst_d;
      s1_lst_q   <= s1_lst_d;
      s1_sht_q   <= s1_sht_d;
      s1_shtn_q  <= s1_shtn_d;
      s1_au_q    <= s1_au_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      f0_q       <= f0_d;
      f1_q       <= f1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pe_psum_ss.sv
// Bench for pe_psum_ss: behavioural pad/FIFO model plus directed literal tests
// and randomized passes. Honors PSUM_SAT_EN for expected arithmetic.
module tb_pe_psum_ss;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  ss_ctl = '0;
  logic [5:0]  psum_last = '0;
  logic [15:0] au_data = '0;
  logic [13:0] pp_addr;
  logic [15:0] pp_rdata = '0;
  logic [15:0] pp_wdata;
  logic        stall, out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  pe_psum_ss dut (
    .clk(clk), .rst(rst), .ss_ctl(ss_ctl), .psum_last(psum_last),
    .au_data(au_data), .pp_addr(pp_addr), .pp_rdata(pp_rdata),
    .pp_wdata(pp_wdata), .stall(stall), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  logic [5:0] pp_raddr, pp_waddr;
  logic       pp_rd, pp_wr;
  assign {pp_raddr, pp_waddr, pp_rd, pp_wr} = pp_addr;

  // physical pad: registered read, write at the edge
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (pp_rd) pp_rdata <= mem[pp_raddr];
    if (pp_wr) mem[pp_waddr] <= pp_wdata;
  end

  typedef struct { int addr; int val; } wr_t;
  int  mmem [64];
  int  mptr = 0;
  int  exp_q [$];
  wr_t wq [$];
  int  got_q [$];
  bit  pop_pend = 0;
  int  n_tests = 0, n_fail = 0;
  int  rdy_mode = 1;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int wrap16(input int x);
    int y;
    y = x & 32'h0000FFFF;
    return (y >= 32768) ? y - 65536 : y;
  endfunction

  function automatic int red(input int x);
`ifdef PSUM_SAT_EN
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
`else
    return wrap16(x);
`endif
  endfunction

  function automatic int calc(input int base, input int au, input bit sht, input int nbits);
    int b;
    b = base;
    if (sht) b = red(b * (1 << nbits));
    return red(b + au);
  endfunction

  // model of an accepted op, evaluated at the accepting edge
  task automatic model_accept(input bit init, input bit fst, input bit lst,
                              input bit sht, input int shtn, input int au);
    int a, base, res;
    if (init) begin
      mptr = 0;
      return;
    end
    a = mptr;
    base = mmem[a];
    foreach (wq[i]) if (wq[i].addr == a) base = wq[i].val;
    if (fst) base = 0;
    res = calc(base, wrap16(au), sht, 1 << shtn);
    wq.push_back('{a, res});
    if (lst) exp_q.push_back(res);
    mptr = (mptr == int'(psum_last)) ? 0 : mptr + 1;
  endtask

  // compare process: outputs, stall and pad writes against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("write_in_rst", pp_wr, 0);
      exp_q.delete();
      wq.delete();
      pop_pend = 0;
    end else begin
      if (pop_pend && exp_q.size() > 0) void'(exp_q.pop_front());
      pop_pend = 0;
      chk("stall", stall, (exp_q.size() >= 2) ? 1 : 0);
      if (out_valid)
        chk("out_data", $signed(out_data), (exp_q.size() > 0) ? exp_q[0] : 999999);
      if (out_valid && out_ready) begin
        pop_pend = 1;
        got_q.push_back(int'($signed(out_data)));
      end
      chk("write_en", pp_wr, (wq.size() != 0) ? 1 : 0);
      if (pp_wr && wq.size() > 0) begin
        chk("waddr", pp_waddr, wq[0].addr);
        chk("wdata", $signed(pp_wdata), wq[0].val);
        mmem[wq[0].addr] = wq[0].val;
        void'(wq.pop_front());
      end
    end
  end

  // out_ready driver: 0 / 1 / random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // present an op (called at posedge+1), wait out stall, accept on next edge
  task automatic op(input bit init, input bit fst, input bit lst, input bit sht,
                    input int shtn, input int au, input int exp_raddr);
    int n;
    ss_ctl  = {1'b1, init, fst, lst, sht, 2'(shtn)};
    au_data = au[15:0];
    n = 0;
    while (stall && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      chk("stall_timeout", stall, 0);
      ss_ctl = '0;
      return;
    end
    if (exp_raddr >= 0) begin
      #1;
      chk("raddr", pp_raddr, exp_raddr);
      chk("read_en", pp_rd, 1);
    end
    @(posedge clk);
    model_accept(init, fst, lst, sht, shtn, au);
    #1;
    ss_ctl = '0;
  endtask

  task automatic idle(input int n);
    ss_ctl = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pp_addr"}, pp_addr, 0);
    chk({tag, "_pp_wdata"}, pp_wdata, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ov_exp;
    foreach (mem[i]) begin mem[i] = '0; mmem[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst = 1'b0;
    mptr = 0;
    idle(1);

    // accumulate: fstpix 1..4 then +10 each, read back via lstpix with au=0
    psum_last = 6'd3;
    op(1, 0, 0, 0, 0, 0, -1);
    for (int i = 1; i <= 4; i++) op(0, 1, 0, 0, 0, i, -1);
    for (int i = 0; i < 4; i++) op(0, 0, 0, 0, 0, 10, i);
    got_q.delete();
    op(0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) op(0, 0, 1, 0, 0, 0, -1);
    idle(8);
    for (int i = 0; i < 4; i++)
      chk("accum_readback", (got_q.size() > i) ? got_q[i] : -1, 11 + i);

    // bit-serial shift through forwarding, out_valid two cycles after accept
    rdy_mode = 0;
    idle(2);
    psum_last = 6'd0;
    op(1, 0, 0, 0, 0, 0, -1);
    op(0, 1, 0, 0, 0, 3, -1);
    op(0, 0, 0, 1, 0, 1, -1);
    op(0, 0, 1, 1, 2, -2, -1);
    chk("lst_valid_t1", out_valid, 0);
    @(posedge clk); #1;
    chk("lst_valid_t2", out_valid, 1);
    chk("bitserial_out", $signed(out_data), 110);
    rdy_mode = 1;
    idle(4);

    // overflow
    got_q.delete();
    op(0, 1, 0, 0, 0, 32767, -1);
    op(0, 0, 1, 0, 0, 1, -1);
    idle(6);
`ifdef PSUM_SAT_EN
    ov_exp = 32767;
`else
    ov_exp = -32768;
`endif
    chk("overflow", (got_q.size() > 0) ? got_q[0] : 0, ov_exp);

    // backpressure
    rdy_mode = 0;
    idle(2);
    psum_last = 6'd2;
    got_q.delete();
    op(1, 0, 0, 0, 0, 0, -1);
    op(0, 1, 1, 0, 0, 5, -1);
    chk("bp_stall_after_1", stall, 0);
    op(0, 1, 1, 0, 0, 6, -1);
    chk("bp_stall_after_2", stall, 1);
    ss_ctl = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    au_data = 16'd7;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_stall_hold", stall, 1);
    end
    rdy_mode = 1;
    op(0, 1, 1, 0, 0, 7, -1);
    idle(8);
    for (int i = 0; i < 3; i++)
      chk("bp_order", (got_q.size() > i) ? got_q[i] : -1, 5 + i);
    chk("bp_count", got_q.size(), 3);

    // init mid-pass
    psum_last = 6'd3;
    op(1, 0, 0, 0, 0, 0, -1);
    op(0, 1, 0, 0, 0, 1, -1);
    op(0, 1, 0, 0, 0, 2, -1);
    op(1, 0, 0, 0, 0, 0, -1);
    op(0, 0, 0, 0, 0, 0, 0);

    // reset while S1 holds an lstpix op and the FIFO is non-empty
    rdy_mode = 0;
    idle(2);
    op(0, 1, 1, 0, 0, 1, -1);
    op(0, 1, 1, 0, 0, 2, -1);
    rst = 1'b1;
    #1;
    chk("rst_no_write", pp_wr, 0);
    @(posedge clk); #1;
    chk_reset_outs("midrst");
    rst = 1'b0;
    mptr = 0;
    rdy_mode = 1;
    got_q.delete();
    idle(1);
    op(0, 0, 1, 0, 0, 0, 0);
    op(0, 0, 1, 0, 0, 0, 1);
    op(0, 0, 1, 0, 0, 0, 2);
    idle(8);
    chk("pad_kept0", (got_q.size() > 0) ? got_q[0] : -1, 1);
    chk("pad_kept1", (got_q.size() > 1) ? got_q[1] : -1, 1);
    chk("pad_kept2", (got_q.size() > 2) ? got_q[2] : -1, 7);

    // randomized passes
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      psum_last = 6'($urandom_range(0, 7));
      op(1, 0, 0, 0, 0, 0, -1);
      for (int k = 0; k < 50; k++) begin
        if ($urandom_range(0, 5) == 0) idle(1);
        op(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768, -1);
      end
    end
    rdy_mode = 1;
    idle(20);
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_wq_empty", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
